led_scan_ctrl: RTL
==================

# led_scan_ctrl

Row-scan sequencer for the LED matrix display. It sits directly upstream of the column counter (`count`). It drives that counter's `inc` and `reset` inputs and consumes its `zero` flag to know when the last column has been shifted. Around each row's shift phase it generates the panel shift clock, latch, output-enable and row address.

## Interface
- `COL_W`, 5: column counter width; row length is 2^COL_W columns. Must equal the `width` of the attached counter.
- `ROW_W`, 4: row address width; 2^ROW_W rows per frame.
- `SHOW_CYCLES`, 64: number of cycles `oe_n` is held low per row; must be ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = clear).
- `enable`  in  1  run request, sampled in IDLE and NEXT.
- `col_zero`  in  1  from the counter's `zero` output; high when the column count is all ones.
- `col_inc`  out  1  to the counter's `inc` input.
- `col_clr`  out  1  to the counter's `reset` input (active high).
- `sclk`  out  1  panel shift clock.
- `latch`  out  1  panel latch strobe.
- `oe_n`  out  1  panel output enable, active low.
- `row`  out  ROW_W  current row address.
- `frame_done`  out  1  one-cycle pulse when the last row completes.

## Operation
- Moore FSM. All outputs are decoded from registered state, or are registers themselves.
- States: IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH, SHOW, NEXT.
- IDLE:
  - `col_clr`=1, `oe_n`=1, all other strobes 0.
  - Goes to CLEAR when `enable`=1.
- CLEAR (1 cycle):
  - `col_clr`=1, `row`<=0.
  - Always goes to SHIFT_LO. This guarantees one full `clk` period with `col_clr` high, so the counter sees a falling edge while clear is asserted.
- SHIFT_LO (1 cycle):
  - `sclk`=0, `col_inc`=0.
  - Registers `last_col` <= `col_zero`. The counter is stable here because it updates on the falling edge.
  - Goes to SHIFT_HI.
- SHIFT_HI (1 cycle):
  - `sclk`=1, `col_inc`=1. The counter increments on the falling edge mid-cycle.
  - Goes to LATCH if `last_col`=1, else back to SHIFT_LO.
  - The counter wraps from all ones to 0 by itself; no clear is issued between rows.
- LATCH (1 cycle): `latch`=1, `oe_n`=1. Goes to SHOW.
- SHOW (SHOW_CYCLES cycles):
  - `oe_n`=0.
  - A down-counter of width clog2(SHOW_CYCLES+1) is loaded on LATCH exit; the FSM leaves SHOW when the counter reaches 0.
- NEXT (1 cycle):
  - `oe_n`=1, `row`<=`row`+1 modulo 2^ROW_W.
  - `frame_done`=1 if `row` was all ones on entry.
  - Goes to SHIFT_LO if `enable`=1, else IDLE.
- `oe_n`=1 in every state except SHOW. `row` changes only in NEXT or CLEAR, both with `oe_n`=1.
- Dropping `enable` mid-row does not abort the row: the row completes through NEXT, then the FSM enters IDLE.
- `enable` is ignored outside IDLE and NEXT.
- Re-enable always restarts at row 0 and column 0 via CLEAR.
- Async reset asserted at any time:
  - State goes to IDLE and `row`=0 immediately, without waiting for a clock.
  - `oe_n`=1, `col_clr`=1; `col_inc`, `sclk`, `latch`, `frame_done` = 0.
- If `col_zero` never asserts (miswired counter), the FSM stays in the shift loop. No watchdog is required.

## Timing
- Reset values: state IDLE, `row`=0, `oe_n`=1, `col_clr`=1; `col_inc`, `sclk`, `latch`, `frame_done` = 0.
- Enable latency: `enable` is sampled high at edge E0. CLEAR occupies cycle E0..E1 and the first SHIFT_LO starts at E1.
- Per row: 2·2^COL_W shift cycles + 1 latch + SHOW_CYCLES + 1 next. With defaults: 64+1+64+1 = 130 cycles.
- Per frame with defaults: 16×130 = 2080 cycles, excluding the single CLEAR cycle.
- `sclk` and `col_inc` pulses: exactly 2^COL_W per row, each 1 cycle high, 50% duty.
- `frame_done`: exactly once per frame, coincident with `row` wrapping from 2^ROW_W−1 to 0.

## Test plan
- Reset:
  - Hold `reset`=0 with `enable`=1 → `oe_n`=1, `col_clr`=1, `row`=0, no `sclk`/`latch` activity.
  - Release `reset` → CLEAR on the next edge, then 32 `sclk` pulses.
- Single row (defaults, with a real `count`(5) attached):
  - 32 `col_inc` pulses, then the counter reads 0 again.
  - `latch` high for exactly 1 cycle at cycle 65 after CLEAR.
  - `oe_n` low for exactly 64 cycles.
  - `row` goes 0→1 at cycle 130.
- Frame wrap:
  - Run 2080 cycles → `row` sequences 0..15 then 0.
  - `frame_done` is high exactly once, in the NEXT cycle of row 15.
- Enable drop:
  - Deassert `enable` during row 3 SHIFT_HI → row 3 still latches and shows for 64 cycles.
  - `row` becomes 4, then IDLE with `col_clr`=1.
  - Re-enable → `row` returns to 0.
- Async reset mid-SHOW:
  - Pull `reset` low between clock edges → `oe_n` rises to 1 and `row`=0 without waiting for an edge.
  - No `latch` or `frame_done` pulse is emitted.

Source files
------------

// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_ctrl
// Brief    : Row-scan sequencer driving an LED panel and its column counter.
// Revision : 1.0 - initial release
// ============================================================================
module led_scan_ctrl #(
  parameter int COL_W       = 5,
  parameter int ROW_W       = 4,
  parameter int SHOW_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             col_zero,
  output logic             col_inc,
  output logic             col_clr,
  output logic             sclk,
  output logic             latch,
  output logic             oe_n,
  output logic [ROW_W-1:0] row,
  output logic             frame_done
);

  localparam int CNT_W = $clog2(SHOW_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_show_load = CNT_W'(SHOW_CYCLES - 1);

  if (COL_W < 1 || ROW_W < 1 || SHOW_CYCLES < 1) begin : g_param_check
    $error("led_scan_ctrl: COL_W, ROW_W and SHOW_CYCLES must all be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_LATCH    = 3'd4,
    S_SHOW     = 3'd5,
    S_NEXT     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] show_cnt_q, show_cnt_d;
  logic             last_col_q, last_col_d;
  logic             frame_done_d;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    show_cnt_d = show_cnt_q;
    last_col_d = last_col_q;
    case (state_q)
      S_IDLE:     if (enable) state_d = S_CLEAR;
      S_CLEAR:    state_d = S_SHIFT_LO;
      // The counter moves on the falling edge, so its flag is settled here.
      S_SHIFT_LO: begin
        last_col_d = col_zero;
        state_d    = S_SHIFT_HI;
      end
      S_SHIFT_HI: state_d = last_col_q ? S_LATCH : S_SHIFT_LO;
      S_LATCH: begin
        state_d    = S_SHOW;
        show_cnt_d = c_show_load;
      end
      S_SHOW: begin
        if (show_cnt_q == '0) state_d = S_NEXT;
        else                  show_cnt_d = show_cnt_q - 1'b1;
      end
      S_NEXT:     state_d = enable ? S_SHIFT_LO : S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    if (state_d == S_CLEAR)     row_d = '0;
    else if (state_d == S_NEXT) row_d = row_q + 1'b1;

    frame_done_d = (state_d == S_NEXT) && (&row_q);
  end

  // Outputs are decoded from the next state so they are registered yet
  // aligned with the state they belong to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      show_cnt_q <= '0;
      last_col_q <= 1'b0;
      col_inc    <= 1'b0;
      col_clr    <= 1'b1;
      sclk       <= 1'b0;
      latch      <= 1'b0;
      oe_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      show_cnt_q <= show_cnt_d;
      last_col_q <= last_col_d;
      col_inc    <= (state_d == S_SHIFT_HI);
      col_clr    <= (state_d == S_IDLE) || (state_d == S_CLEAR);
      sclk       <= (state_d == S_SHIFT_HI);
      latch      <= (state_d == S_LATCH);
      oe_n       <= (state_d != S_SHOW);
      frame_done <= frame_done_d;
    end
  end

  assign row = row_q;

endmodule
`default_nettype wire
